// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte-wise write reception and read transmission over an open-drain SDA.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i2c_clock_in,
    input  logic       i2c_reset_n_in,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data_in,
    output logic       tx_data_req,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_hist_reg;
    logic                   sda_hist_reg;
    logic [7:0]             sh_reg;
    logic [2:0]             bit_cnt_reg;
    logic                   byte_done_reg;
    logic                   rw_reg;
    logic                   sda_low_reg;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign i2c_sda = sda_low_reg ? 1'b0 : 1'bz;

    // Synchronisers reset to the idle-bus level so no false edge follows reset.
    always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
        if (!i2c_reset_n_in) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i2c_scl};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], i2c_sda};
            scl_hist_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_hist_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_reg;
    assign scl_fall  = ~scl_s & scl_hist_reg;
    assign start_det = scl_s & scl_hist_reg & sda_hist_reg & ~sda_s;
    assign stop_det  = scl_s & scl_hist_reg & ~sda_hist_reg & sda_s;

    always_ff @(posedge i2c_clock_in or negedge i2c_reset_n_in) begin
        if (!i2c_reset_n_in) begin
            state_reg     <= IDLE;
            sh_reg        <= 8'h00;
            bit_cnt_reg   <= 3'd7;
            byte_done_reg <= 1'b0;
            rw_reg        <= 1'b0;
            sda_low_reg   <= 1'b0;
            rx_data_out   <= 8'h00;
            rx_valid      <= 1'b0;
            tx_data_req   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_data_req <= 1'b0;
            if (start_det) begin
                state_reg     <= ADDR;
                bit_cnt_reg   <= 3'd7;
                byte_done_reg <= 1'b0;
                sda_low_reg   <= 1'b0;
            end else if (stop_det) begin
                state_reg   <= IDLE;
                sda_low_reg <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: ;
                    ADDR, WRITE: begin
                        if (scl_rise) begin
                            sh_reg <= {sh_reg[6:0], sda_s};
                            if (bit_cnt_reg == 3'd0) byte_done_reg <= 1'b1;
                            else                     bit_cnt_reg   <= bit_cnt_reg - 3'd1;
                        end else if (scl_fall && byte_done_reg) begin
                            if (state_reg == WRITE) begin
                                rx_data_out <= sh_reg;
                                rx_valid    <= 1'b1;
                                sda_low_reg <= 1'b1;
                                state_reg   <= WRITE_ACK;
                            end else if (sh_reg[7:1] == SLAVE_ADDR) begin
                                sda_low_reg <= 1'b1;
                                busy        <= 1'b1;
                                rw_reg      <= sh_reg[0];
                                state_reg   <= ADDR_ACK;
                            end else begin
                                busy      <= 1'b0;
                                state_reg <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK, WRITE_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_reg   <= 3'd7;
                            byte_done_reg <= 1'b0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                tx_data_req <= 1'b1;
                                sh_reg      <= tx_data_in;
                                sda_low_reg <= ~tx_data_in[7];
                                state_reg   <= READ;
                            end else begin
                                sda_low_reg <= 1'b0;
                                state_reg   <= WRITE;
                            end
                        end
                    end
                    READ: begin
                        // SDA only changes on falling SCL so it is stable through each high phase.
                        if (scl_rise) begin
                            if (bit_cnt_reg == 3'd0) byte_done_reg <= 1'b1;
                            else                     bit_cnt_reg   <= bit_cnt_reg - 3'd1;
                        end else if (scl_fall) begin
                            if (byte_done_reg) begin
                                sda_low_reg <= 1'b0;
                                state_reg   <= READ_ACK;
                            end else begin
                                sh_reg      <= {sh_reg[6:0], 1'b0};
                                sda_low_reg <= ~sh_reg[6];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise && sda_s) begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else if (scl_fall) begin
                            tx_data_req   <= 1'b1;
                            sh_reg        <= tx_data_in;
                            sda_low_reg   <= ~tx_data_in[7];
                            bit_cnt_reg   <= 3'd7;
                            byte_done_reg <= 1'b0;
                            state_reg     <= READ;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master with a scoreboard on
// rx_valid and directed checks on ACKs, read-back bytes and status outputs.
module tb_i2c_slave_responder;

    localparam int Q = 5;  // system clocks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_req;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       busy;
    wire        sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_responder #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .i2c_clock_in  (clk),
        .i2c_reset_n_in(rst_n),
        .i2c_scl       (scl),
        .i2c_sda       (sda),
        .tx_data_in    (tx_data),
        .tx_data_req   (tx_data_req),
        .rx_data_out   (rx_data_out),
        .rx_valid      (rx_valid),
        .busy          (busy)
    );

    int         checks = 0;
    int         failures = 0;
    int         req_count = 0;
    int         drive_viol = 0;
    logic       watch_no_drive = 1'b0;
    logic [7:0] exp_rx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor: each rx_valid pops one expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", rx_data_out);
                end else begin
                    check("rx_byte", {24'h0, rx_data_out}, {24'h0, exp_rx.pop_front()});
                end
            end
            if (tx_data_req) req_count++;
            if (watch_no_drive && !m_sda_low && sda === 1'b0) drive_viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_clks(Q);
        scl = 1'b1;       wait_clks(Q);
        m_sda_low = 1'b1; wait_clks(Q);
        scl = 1'b0;       wait_clks(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_clks(Q);
        scl = 1'b1;       wait_clks(Q);
        m_sda_low = 1'b0; wait_clks(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_clks(Q);
        scl = 1'b1;     wait_clks(2 * Q);
        scl = 1'b0;     wait_clks(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_clks(Q);
        scl = 1'b1;       wait_clks(Q);
        b = sda;          wait_clks(Q);
        scl = 1'b0;       wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         req_base;

        // Reset state
        wait_clks(4);
        check("reset_sda", {31'h0, sda}, 32'h1);
        check("reset_rx_data", {24'h0, rx_data_out}, 32'h0);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_tx_req", {31'h0, tx_data_req}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        wait_clks(4);

        // Write 0xA5, 0x3C to 0x50
        i2c_start();
        write_byte(8'hA0, ack); check("wr_addr_ack", {31'h0, ack}, 32'h0);
        check("wr_busy", {31'h0, busy}, 32'h1);
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ack); check("wr_d0_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h3C);
        write_byte(8'h3C, ack); check("wr_d1_ack", {31'h0, ack}, 32'h0);
        check("wr_busy_before_stop", {31'h0, busy}, 32'h1);
        i2c_stop();
        check("wr_busy_after_stop", {31'h0, busy}, 32'h0);
        check("wr_rx_hold", {24'h0, rx_data_out}, 32'h3C);

        // Wrong address 0x51
        watch_no_drive = 1'b1;
        i2c_start();
        write_byte(8'hA2, ack); check("mis_addr_nack", {31'h0, ack}, 32'h1);
        check("mis_busy", {31'h0, busy}, 32'h0);
        write_byte(8'h77, ack); check("mis_data_nack", {31'h0, ack}, 32'h1);
        i2c_stop();
        watch_no_drive = 1'b0;
        check("mis_no_drive", drive_viol, 32'h0);
        check("mis_rx_hold", {24'h0, rx_data_out}, 32'h3C);

        // Read 0xC3, 0x5A with ACK then NACK
        req_base = req_count;
        tx_data = 8'hC3;
        i2c_start();
        write_byte(8'hA1, ack); check("rd_addr_ack", {31'h0, ack}, 32'h0);
        tx_data = 8'h5A;
        read_byte(rd, 1'b0); check("rd_byte0", {24'h0, rd}, 32'hC3);
        read_byte(rd, 1'b1); check("rd_byte1", {24'h0, rd}, 32'h5A);
        wait_clks(2);
        check("rd_sda_released", {31'h0, sda}, 32'h1);
        check("rd_busy_after_nack", {31'h0, busy}, 32'h0);
        check("rd_req_count", req_count - req_base, 32'h2);
        i2c_stop();

        // Write 0x11, repeated START, read
        req_base = req_count;
        i2c_start();
        write_byte(8'hA0, ack); check("rs_wr_addr_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack); check("rs_wr_d_ack", {31'h0, ack}, 32'h0);
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'hA1, ack); check("rs_rd_addr_ack", {31'h0, ack}, 32'h0);
        check("rs_rx_data", {24'h0, rx_data_out}, 32'h11);
        read_byte(rd, 1'b1); check("rs_rd_byte", {24'h0, rd}, 32'h96);
        check("rs_req_count", req_count - req_base, 32'h1);
        i2c_stop();

        // Reset asserted mid-byte during READ
        tx_data = 8'h00;
        i2c_start();
        write_byte(8'hA1, ack); check("rst_addr_ack", {31'h0, ack}, 32'h0);
        for (int i = 0; i < 3; i++) read_bit(ack);
        check("rst_dut_driving", {31'h0, sda}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_sda_z", {31'h0, sda}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rx_data", {24'h0, rx_data_out}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_tx_req", {31'h0, tx_data_req}, 32'h0);
        wait_clks(2);
        scl = 1'b1;
        m_sda_low = 1'b0;
        wait_clks(Q);
        rst_n = 1'b1;
        wait_clks(Q);
        i2c_start();
        write_byte(8'hA0, ack); check("post_rst_addr_ack", {31'h0, ack}, 32'h0);
        exp_rx.push_back(8'h42);
        write_byte(8'h42, ack); check("post_rst_d_ack", {31'h0, ack}, 32'h0);
        i2c_stop();

        // STOP after 4 bits of a written byte
        i2c_start();
        write_byte(8'hA0, ack); check("abort_addr_ack", {31'h0, ack}, 32'h0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        wait_clks(2 * Q);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rx_hold", {24'h0, rx_data_out}, 32'h42);
        check("abort_sda", {31'h0, sda}, 32'h1);

        wait_clks(4);
        check("rx_queue_drained", exp_rx.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
